// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side memory port (request, write data, 4-beat read response)
interface mem_arbiter_if #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128
);
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_BITS-1:0]   req_addr;
  logic                   req_rw;
  logic                   req_data_valid;
  logic                   req_data_ready;
  logic [DATA_BITS-1:0]   req_data_bits;
  logic [DATA_BITS/8-1:0] req_data_mask;
  logic                   resp_valid;
  logic [DATA_BITS-1:0]   resp_data;
  modport master (
    output req_valid, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask,
    input  req_ready, req_data_ready, resp_valid, resp_data
  );
  modport slave (
    input  req_valid, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask,
    output req_ready, req_data_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter of icache/dcache onto one memory port, one transaction outstanding
module mem_arbiter #(
  parameter int ADDR_BITS  = 28,
  parameter int DATA_BITS  = 128,
  parameter int RESP_BEATS = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  ic,
  mem_arbiter_if.slave  dc,
  mem_arbiter_if.master mem
);
  localparam int BW = RESP_BEATS > 1 ? $clog2(RESP_BEATS) : 1;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t          state, state_n;
  logic            owner, owner_n, last, last_n;
  logic            req_done, req_done_n, data_done, data_done_n;
  logic [BW-1:0]   beat, beat_n;
  logic            o_req_valid, o_rw, o_data_valid, rv, dv, rd, dd;
  assign o_req_valid  = owner ? dc.req_valid      : ic.req_valid;
  assign o_rw         = owner ? dc.req_rw         : ic.req_rw;
  assign o_data_valid = owner ? dc.req_data_valid : ic.req_data_valid;
  assign rv = o_req_valid & ~req_done;
  assign dv = o_data_valid & o_rw & ~data_done;
  assign rd = req_done | (rv & mem.req_ready);
  assign dd = data_done | (dv & mem.req_data_ready);
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b0;
      req_done  <= 1'b0;
      data_done <= 1'b0;
      beat      <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      last      <= last_n;
      req_done  <= req_done_n;
      data_done <= data_done_n;
      beat      <= beat_n;
    end
  end
  // Reset is treated as IDLE so every valid/ready is low while it is held.
  always_comb begin
    state_n            = state;
    owner_n            = owner;
    last_n             = last;
    req_done_n         = req_done;
    data_done_n        = data_done;
    beat_n             = beat;
    mem.req_valid      = 1'b0;
    mem.req_data_valid = 1'b0;
    mem.req_addr       = owner ? dc.req_addr      : ic.req_addr;
    mem.req_rw         = o_rw;
    mem.req_data_bits  = owner ? dc.req_data_bits : ic.req_data_bits;
    mem.req_data_mask  = owner ? dc.req_data_mask : ic.req_data_mask;
    ic.req_ready       = 1'b0;
    ic.req_data_ready  = 1'b0;
    dc.req_ready       = 1'b0;
    dc.req_data_ready  = 1'b0;
    ic.resp_valid      = 1'b0;
    dc.resp_valid      = 1'b0;
    ic.resp_data       = mem.resp_data;
    dc.resp_data       = mem.resp_data;
    case (reset ? IDLE : state)
      REQ: begin
        mem.req_valid      = rv;
        mem.req_data_valid = dv;
        ic.req_ready       = ~owner & mem.req_ready & ~req_done;
        dc.req_ready       = owner & mem.req_ready & ~req_done;
        ic.req_data_ready  = ~owner & mem.req_data_ready & o_rw & ~data_done;
        dc.req_data_ready  = owner & mem.req_data_ready & o_rw & ~data_done;
        if (!o_rw) begin
          if (rv && mem.req_ready) state_n = RESP;
        end else begin
          req_done_n  = rd;
          data_done_n = dd;
          if (rd && dd) begin
            last_n  = owner;
            state_n = IDLE;
          end
        end
      end
      RESP: begin
        ic.resp_valid = mem.resp_valid & ~owner;
        dc.resp_valid = mem.resp_valid & owner;
        if (mem.resp_valid) begin
          beat_n = beat + BW'(1);
          if (beat == BW'(RESP_BEATS - 1)) begin
            last_n  = owner;
            state_n = IDLE;
          end
        end
      end
      default: begin
        if (ic.req_valid || dc.req_valid) begin
          owner_n     = (ic.req_valid && dc.req_valid) ? ~last : dc.req_valid;
          req_done_n  = 1'b0;
          data_done_n = 1'b0;
          beat_n      = '0;
          state_n     = REQ;
        end
      end
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant order, write handshakes, beat routing and reset
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  always #5 clk = ~clk;
  mem_arbiter_if #(.ADDR_BITS(28), .DATA_BITS(128)) ic_if ();
  mem_arbiter_if #(.ADDR_BITS(28), .DATA_BITS(128)) dc_if ();
  mem_arbiter_if #(.ADDR_BITS(28), .DATA_BITS(128)) mem_if ();
  mem_arbiter #(.ADDR_BITS(28), .DATA_BITS(128), .RESP_BEATS(4)) dut (
    .clk(clk), .reset(reset), .ic(ic_if.slave), .dc(dc_if.slave), .mem(mem_if.master)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] bd(input int i);
    return {4{32'hD000_0000 + 32'(i)}};
  endfunction
  task automatic clear();
    ic_if.req_valid = 0; ic_if.req_addr = '0; ic_if.req_rw = 0;
    ic_if.req_data_valid = 0; ic_if.req_data_bits = '0; ic_if.req_data_mask = '0;
    dc_if.req_valid = 0; dc_if.req_addr = '0; dc_if.req_rw = 0;
    dc_if.req_data_valid = 0; dc_if.req_data_bits = '0; dc_if.req_data_mask = '0;
    mem_if.req_ready = 0; mem_if.req_data_ready = 0;
    mem_if.resp_valid = 0; mem_if.resp_data = '0;
  endtask
  task automatic do_reset();
    clear();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask
  // One beat per call, each followed by n_gap idle cycles in which nothing may be forwarded.
  task automatic beat(input logic to_dc, input int i, input int n_gap);
    mem_if.resp_valid = 1;
    mem_if.resp_data = bd(i);
    #1;
    chk($sformatf("beat%0d_ic_valid", i), ic_if.resp_valid, !to_dc);
    chk($sformatf("beat%0d_dc_valid", i), dc_if.resp_valid, to_dc);
    chk($sformatf("beat%0d_data", i), to_dc ? dc_if.resp_data : ic_if.resp_data, bd(i));
    tick();
    mem_if.resp_valid = 0;
    for (int g = 0; g < n_gap; g++) begin
      #1;
      chk("gap_mem_req_valid", mem_if.req_valid, 1'b0);
      chk("gap_resp_valid", {ic_if.resp_valid, dc_if.resp_valid}, 2'b00);
      tick();
    end
  endtask
  task automatic read_grant(input logic to_dc, input logic [27:0] addr);
    #1;
    chk("idle_mem_req_valid", mem_if.req_valid, 1'b0);
    tick();
    #1;
    chk("grant_mem_req_valid", mem_if.req_valid, 1'b1);
    chk("grant_mem_req_addr", mem_if.req_addr, addr);
    chk("grant_ic_ready", ic_if.req_ready, !to_dc);
    chk("grant_dc_ready", dc_if.req_ready, to_dc);
    tick();
  endtask
  initial begin
    do_reset();
    reset = 1;
    ic_if.req_valid = 1;
    #1;
    chk("reset_mem_req_valid", mem_if.req_valid, 1'b0);
    chk("reset_ic_ready", ic_if.req_ready, 1'b0);
    tick();
    reset = 0;
    ic_if.req_valid = 0;
    // single icache read
    ic_if.req_valid = 1; ic_if.req_addr = 28'h0000123; mem_if.req_ready = 1;
    read_grant(1'b0, 28'h0000123);
    ic_if.req_valid = 0;
    for (int i = 0; i < 4; i++) beat(1'b0, i, 0);
    mem_if.resp_valid = 1; mem_if.resp_data = bd(9);
    #1;
    chk("stray_ic_valid", ic_if.resp_valid, 1'b0);
    chk("stray_dc_valid", dc_if.resp_valid, 1'b0);
    chk("stray_mem_req_valid", mem_if.req_valid, 1'b0);
    tick();
    mem_if.resp_valid = 0;
    #1;
    chk("stray_state_idle", dut.state, 2'd0);
    // simultaneous reads: dcache first, then alternate
    do_reset();
    ic_if.req_valid = 1; ic_if.req_addr = 28'h0000111;
    dc_if.req_valid = 1; dc_if.req_addr = 28'h0000222;
    mem_if.req_ready = 1;
    read_grant(1'b1, 28'h0000222);
    for (int i = 0; i < 4; i++) beat(1'b1, i, 0);
    read_grant(1'b0, 28'h0000111);
    for (int i = 0; i < 4; i++) beat(1'b0, i, 0);
    read_grant(1'b1, 28'h0000222);
    for (int i = 0; i < 4; i++) beat(1'b1, i, 0);
    read_grant(1'b0, 28'h0000111);
    // write with staggered handshakes
    do_reset();
    dc_if.req_valid = 1; dc_if.req_addr = 28'hABCDEF0; dc_if.req_rw = 1;
    dc_if.req_data_valid = 1; dc_if.req_data_mask = 16'h00F0;
    dc_if.req_data_bits = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    tick();
    mem_if.req_ready = 1;
    #1;
    chk("wr_c1_req_valid", mem_if.req_valid, 1'b1);
    chk("wr_c1_addr", mem_if.req_addr, 28'hABCDEF0);
    chk("wr_c1_rw", mem_if.req_rw, 1'b1);
    chk("wr_c1_data_valid", mem_if.req_data_valid, 1'b1);
    chk("wr_c1_bits", mem_if.req_data_bits, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    chk("wr_c1_mask", mem_if.req_data_mask, 16'h00F0);
    chk("wr_c1_dc_ready", dc_if.req_ready, 1'b1);
    chk("wr_c1_dc_data_ready", dc_if.req_data_ready, 1'b0);
    tick();
    #1;
    chk("wr_c2_req_valid", mem_if.req_valid, 1'b0);
    chk("wr_c2_dc_ready", dc_if.req_ready, 1'b0);
    chk("wr_c2_data_valid", mem_if.req_data_valid, 1'b1);
    tick();
    mem_if.req_data_ready = 1;
    #1;
    chk("wr_c3_data_valid", mem_if.req_data_valid, 1'b1);
    chk("wr_c3_dc_data_ready", dc_if.req_data_ready, 1'b1);
    tick();
    clear();
    mem_if.req_ready = 1;
    mem_if.resp_valid = 1;
    ic_if.req_valid = 1; ic_if.req_addr = 28'h0000777;
    dc_if.req_valid = 1; dc_if.req_addr = 28'h0000888;
    #1;
    chk("wr_c4_state_idle", dut.state, 2'd0);
    chk("wr_c4_dc_resp_valid", dc_if.resp_valid, 1'b0);
    mem_if.resp_valid = 0;
    read_grant(1'b0, 28'h0000777);
    // gapped response with a pending icache request
    do_reset();
    dc_if.req_valid = 1; dc_if.req_addr = 28'h0000333; mem_if.req_ready = 1;
    read_grant(1'b1, 28'h0000333);
    dc_if.req_valid = 0;
    ic_if.req_valid = 1; ic_if.req_addr = 28'h0000444;
    beat(1'b1, 0, 0);
    beat(1'b1, 1, 2);
    beat(1'b1, 2, 5);
    beat(1'b1, 3, 0);
    read_grant(1'b0, 28'h0000444);
    // reset in the middle of a read
    do_reset();
    ic_if.req_valid = 1; ic_if.req_addr = 28'h0000555; mem_if.req_ready = 1;
    read_grant(1'b0, 28'h0000555);
    ic_if.req_valid = 0;
    beat(1'b0, 0, 0);
    beat(1'b0, 1, 0);
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("rst_mid_mem_req_valid", mem_if.req_valid, 1'b0);
    chk("rst_mid_readies", {ic_if.req_ready, dc_if.req_ready, ic_if.req_data_ready, dc_if.req_data_ready}, 4'b0);
    for (int i = 2; i < 4; i++) begin
      mem_if.resp_valid = 1; mem_if.resp_data = bd(i);
      #1;
      chk("rst_drop_resp_valid", {ic_if.resp_valid, dc_if.resp_valid}, 2'b00);
      tick();
    end
    mem_if.resp_valid = 0;
    ic_if.req_valid = 1; ic_if.req_addr = 28'h0000666;
    read_grant(1'b0, 28'h0000666);
    ic_if.req_valid = 0;
    for (int i = 4; i < 8; i++) beat(1'b0, i, 0);
    #1;
    chk("post_rst_idle", dut.state, 2'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-client memory arbiter between the instruction cache, the data cache and the single shared main-memory port. Each cache drives a cache-side memory interface: 28-bit line-chunk address, 128-bit data, 16-bit byte mask, and a 4-beat read response. The arbiter grants one client at a time with two-way round-robin. It forwards that client's request and write data to memory. It routes read-response beats back only to the owning client. At most one transaction is outstanding at any time.

## Interface
- `ADDR_BITS`, 28, memory chunk address width (word address bits [29:2]).
- `DATA_BITS`, 128, memory data width; mask width is `DATA_BITS/8`.
- `RESP_BEATS`, 4, response beats per read (one 512-bit line).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `ic_req_valid` in 1, `ic_req_ready` out 1, `ic_req_addr` in `ADDR_BITS`, `ic_req_rw` in 1: icache request channel.
- `ic_req_data_valid` in 1, `ic_req_data_ready` out 1, `ic_req_data_bits` in `DATA_BITS`, `ic_req_data_mask` in `DATA_BITS/8`: icache write data.
- `ic_resp_valid` out 1, `ic_resp_data` out `DATA_BITS`: icache response.
- `dc_*` ports: same set as `ic_*`, for the dcache.
- `mem_req_valid` out 1, `mem_req_ready` in 1, `mem_req_addr` out `ADDR_BITS`, `mem_req_rw` out 1: memory request.
- `mem_req_data_valid` out 1, `mem_req_data_ready` in 1, `mem_req_data_bits` out `DATA_BITS`, `mem_req_data_mask` out `DATA_BITS/8`: memory write data.
- `mem_resp_valid` in 1, `mem_resp_data` in `DATA_BITS`: memory response.

## Operation
- Registers:
  - `state` ∈ {IDLE, REQ, RESP}.
  - `owner` (0 = icache, 1 = dcache).
  - `last` (last granted client).
  - `req_done`, `data_done` flags.
  - 2-bit `beat` counter, width `ceilLog2(RESP_BEATS)`.
- **IDLE:** all downstream valids and upstream readies are 0.
  - Candidate clients: those with `*_req_valid` = 1.
  - One candidate → it wins.
  - Both → the client ≠ `last` wins.
  - On a win: register `owner`, clear `req_done`/`data_done` and `beat`, go to REQ.
- **REQ:** mux the owner's addr, rw, data and mask onto the `mem_*` outputs.
  - `mem_req_valid` = owner `req_valid` & !`req_done`.
  - `mem_req_data_valid` = owner `data_valid` & owner `rw` & !`data_done`.
  - Owner readies are `mem_req_ready` / `mem_req_data_ready` gated by the same terms. The non-owner's readies are 0.
  - Read (rw = 0): on the request handshake, go to RESP.
  - Write (rw = 1): set each flag on its handshake. When both are done (same cycle or different cycles), set `last` ← `owner` and go to IDLE. No response is expected.
- **RESP:** each `mem_resp_valid` cycle raises `<owner>_resp_valid` and increments `beat`.
  - On the beat where `beat` = `RESP_BEATS`-1: set `last` ← `owner` and go to IDLE.
  - Beats need not be consecutive.
- `ic_resp_data` = `dc_resp_data` = `mem_resp_data` always. Only the valid is routed.
- `mem_resp_valid` outside RESP is dropped; no client sees it.
- Clients must hold their request signals stable until the handshake. A client dropping valid in REQ stalls the arbiter in REQ; this is legal and the arbiter does not time out.
- Reset: `state` = IDLE, `last` = 0 (so dcache wins the first tie), flags and `beat` = 0.
- All valid/ready outputs are 0 during and after reset. `mem_req_addr`, `mem_req_data_bits` and `mem_req_data_mask` are don't-care while their valid is 0.
- Reset mid-transaction abandons it. Beats that arrive after reset are dropped by the IDLE rule.

## Timing
- Grant latency: a request asserted in cycle N (arbiter in IDLE) appears on `mem_req_valid` in cycle N+1.
- All `mem_*` outputs, client readies and client `resp_valid` are combinational from registered state and current inputs. No combinational path runs from `mem_req_ready` to `mem_req_valid`.
- Minimum read occupancy: 1 (IDLE) + 1 (REQ) + `RESP_BEATS` cycles. The next grant's IDLE cycle immediately follows the last beat.
- Minimum write occupancy: 2 cycles when both handshakes complete in the first REQ cycle.
- A single client requesting continuously is granted every transaction.

## Test plan
- **Single icache read:** `ic_req_valid` = 1, addr 0x0000123, rw = 0, `mem_req_ready` = 1.
  - `mem_req_addr` = 0x0000123 one cycle later.
  - 4 beats D0–D3 produce exactly 4 `ic_resp_valid` pulses with matching data.
  - `dc_resp_valid` stays 0 throughout.
- **Simultaneous read requests after reset:** dcache is granted first.
  - icache is granted in the cycle after dcache's 4th beat + 1.
  - With both still requesting, grants then alternate ic, dc, ic.
- **Write with staggered handshakes:** dcache write, addr 0xABCDEF0, mask 0x00F0.
  - `mem_req_ready` is given in cycle 1; `mem_req_data_ready` is given in cycle 3.
  - Forwarded bits and mask are exact.
  - `mem_req_valid` deasserts after cycle 1.
  - Return to IDLE after cycle 3; no response is routed.
- **Gapped response:** beats arrive with 0, 2 and 5 idle cycles between them.
  - The read completes only after the 4th beat.
  - A pending icache request is not forwarded before then.
- **Stray beat in IDLE:** `mem_resp_valid` pulse in IDLE → both `*_resp_valid` stay 0 and the state is unchanged.
- **Reset mid-read:** reset after beat 2.
  - All outputs are 0 in the next cycle.
  - Beats 3–4 that arrive afterwards are dropped.
  - A fresh icache read then completes normally.
